// File: rtl/capture_wrap_if.sv
// AXI4 bus bundle shared by the master, the slave and any passive observers.
// The monitor modport takes every signal as an input, so an observer can never drive the bus.
interface capture_wrap_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1
);
    // Write address channel
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_region;
    logic [3:0]              aw_qos;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    // Write data channel
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    // Write response channel
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    // Read address channel
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_region;
    logic [3:0]              ar_qos;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    // Read data channel
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_region, ar_qos, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_region, ar_qos, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport monitor (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
              aw_region, aw_qos, aw_user, aw_valid, aw_ready,
        input w_data, w_strb, w_last, w_user, w_valid, w_ready,
        input b_id, b_resp, b_user, b_valid, b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
              ar_region, ar_qos, ar_user, ar_valid, ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid, r_ready
    );

endinterface

// File: rtl/capture_wrap.sv
// Passive AXI4 monitor. Each cycle it registers a flat snapshot of all five channels together
// with handshake flags, a free-running timestamp and per-channel handshake counters, for the
// trace capture memory. Layout, LSB upward:
//   fire[4:0] | AW | W | B | AR | R | timestamp[31:0] | cnt_aw | cnt_w | cnt_b | cnt_ar | cnt_r
// with zero padding above the used width.
module capture_wrap #(
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned CAPTURE_WIDTH = 1230
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    capture_wrap_if.monitor          capture_if,
    output logic [CAPTURE_WIDTH-1:0] capture,
    output logic [4:0]               fire_o
);

    localparam int unsigned TS_WIDTH  = 32;
    localparam int unsigned CNT_WIDTH = 16;
    localparam int unsigned NUM_CH    = 5;

    // Address channel: id, addr, len(8), size(3), burst(2), lock, cache(4), prot(3),
    // region(4), qos(4), user, valid, ready
    localparam int unsigned AX_WIDTH = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4
                                     + USER_WIDTH + 2;
    localparam int unsigned W_WIDTH  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH + 2;
    localparam int unsigned B_WIDTH  = ID_WIDTH + 2 + USER_WIDTH + 2;
    localparam int unsigned R_WIDTH  = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH + 2;

    localparam int unsigned USED_WIDTH = NUM_CH + 2 * AX_WIDTH + W_WIDTH + B_WIDTH + R_WIDTH
                                       + TS_WIDTH + NUM_CH * CNT_WIDTH;

    // A capture vector too narrow for the configured bus would silently drop fields.
    if (USED_WIDTH > CAPTURE_WIDTH) begin : g_width_check
        $error("capture_wrap: CAPTURE_WIDTH is smaller than the packed snapshot width");
    end

    if (USER_WIDTH < 1) begin : g_user_check
        $error("capture_wrap: USER_WIDTH must be at least 1");
    end

    // Handshake flags in capture order: bit0=aw, bit1=w, bit2=b, bit3=ar, bit4=r
    logic [NUM_CH-1:0] fire_now;

    // Packed channel fields, MSB-first in the signal order of each channel
    logic [AX_WIDTH-1:0] aw_field;
    logic [W_WIDTH-1:0]  w_field;
    logic [B_WIDTH-1:0]  b_field;
    logic [AX_WIDTH-1:0] ar_field;
    logic [R_WIDTH-1:0]  r_field;

    // Timestamp and counters; *_now is the value after an optional clear this cycle
    logic [TS_WIDTH-1:0]                ts_q;
    logic [TS_WIDTH-1:0]                ts_d;
    logic [TS_WIDTH-1:0]                ts_now;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]   cnt_q;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]   cnt_d;

    logic [USED_WIDTH-1:0]    snapshot;
    logic [CAPTURE_WIDTH-1:0] capture_d;
    logic [CAPTURE_WIDTH-1:0] capture_q;
    logic [NUM_CH-1:0]        fire_q;

    // Kept as a continuous assignment so the timestamp base is a single, clearly defined point
    assign ts_now = clr_i ? '0 : ts_q;

    // Pack every channel and detect handshakes from the sampled bus values
    always_comb begin
        fire_now = {capture_if.r_valid  & capture_if.r_ready,
                    capture_if.ar_valid & capture_if.ar_ready,
                    capture_if.b_valid  & capture_if.b_ready,
                    capture_if.w_valid  & capture_if.w_ready,
                    capture_if.aw_valid & capture_if.aw_ready};

        aw_field = {capture_if.aw_id, capture_if.aw_addr, capture_if.aw_len,
                    capture_if.aw_size, capture_if.aw_burst, capture_if.aw_lock,
                    capture_if.aw_cache, capture_if.aw_prot, capture_if.aw_region,
                    capture_if.aw_qos, capture_if.aw_user, capture_if.aw_valid,
                    capture_if.aw_ready};

        w_field  = {capture_if.w_data, capture_if.w_strb, capture_if.w_last,
                    capture_if.w_user, capture_if.w_valid, capture_if.w_ready};

        b_field  = {capture_if.b_id, capture_if.b_resp, capture_if.b_user,
                    capture_if.b_valid, capture_if.b_ready};

        ar_field = {capture_if.ar_id, capture_if.ar_addr, capture_if.ar_len,
                    capture_if.ar_size, capture_if.ar_burst, capture_if.ar_lock,
                    capture_if.ar_cache, capture_if.ar_prot, capture_if.ar_region,
                    capture_if.ar_qos, capture_if.ar_user, capture_if.ar_valid,
                    capture_if.ar_ready};

        r_field  = {capture_if.r_id, capture_if.r_data, capture_if.r_resp,
                    capture_if.r_last, capture_if.r_user, capture_if.r_valid,
                    capture_if.r_ready};
    end

    // Next timestamp and counters; the captured counters already include this cycle's fire
    always_comb begin
        ts_d = ts_now + TS_WIDTH'(1);
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = (clr_i ? '0 : cnt_q[i]) + CNT_WIDTH'(fire_now[i]);
        end
    end

    // Assemble the capture word; counters pack with cnt_aw lowest
    always_comb begin
        snapshot = {cnt_d, ts_now, r_field, ar_field, b_field, w_field, aw_field, fire_now};
        capture_d = '0;
        capture_d[USED_WIDTH-1:0] = snapshot;
    end

    // State and output registers; reset overrides clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q      <= '0;
            cnt_q     <= '0;
            capture_q <= '0;
            fire_q    <= '0;
        end else begin
            ts_q      <= ts_d;
            cnt_q     <= cnt_d;
            capture_q <= capture_d;
            fire_q    <= fire_now;
        end
    end

    assign capture = capture_q;
    assign fire_o  = fire_q;

endmodule

// File: tb/tb_capture_wrap.sv
// Directed bench for capture_wrap: a vector table for handshake patterns plus hand-written
// sequences for reset, stalled handshakes, clear, counter and timestamp wrap.
module tb_capture_wrap;

    localparam int unsigned IDW = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned UW  = 1;
    localparam int unsigned CW  = 1230;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          clr_i;
    logic [CW-1:0] capture;
    logic [4:0]    fire_o;

    always #5 clk = ~clk;

    capture_wrap_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

    capture_wrap #(
        .ID_WIDTH      (IDW),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .USER_WIDTH    (UW),
        .CAPTURE_WIDTH (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .capture_if (bus),
        .capture    (capture),
        .fire_o     (fire_o)
    );

    typedef struct {
        logic [4:0]  valid;   // {r,ar,b,w,aw}
        logic [4:0]  ready;
        logic [31:0] addr;
        logic [63:0] data;
        logic [4:0]  fire;    // hand-computed expected flags
    } vec_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state tracked independently of the DUT
    logic [31:0]      ts_m;
    logic [4:0][15:0] cnt_m;

    task automatic check(input string name, input logic [415:0] act, input logic [415:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected capture low 412 bits from the layout description and current bus values
    function automatic logic [411:0] model(input logic [4:0] f, input logic [31:0] ts,
                                           input logic [4:0][15:0] c);
        logic [73:0] r_f;
        logic [67:0] ar_f;
        logic [8:0]  b_f;
        logic [75:0] w_f;
        logic [67:0] aw_f;
        r_f  = {bus.r_id, bus.r_data, bus.r_resp, bus.r_last, bus.r_user, bus.r_valid,
                bus.r_ready};
        ar_f = {bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst, bus.ar_lock,
                bus.ar_cache, bus.ar_prot, bus.ar_region, bus.ar_qos, bus.ar_user,
                bus.ar_valid, bus.ar_ready};
        b_f  = {bus.b_id, bus.b_resp, bus.b_user, bus.b_valid, bus.b_ready};
        w_f  = {bus.w_data, bus.w_strb, bus.w_last, bus.w_user, bus.w_valid, bus.w_ready};
        aw_f = {bus.aw_id, bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_lock,
                bus.aw_cache, bus.aw_prot, bus.aw_region, bus.aw_qos, bus.aw_user,
                bus.aw_valid, bus.aw_ready};
        return {c[4], c[3], c[2], c[1], c[0], ts, r_f, ar_f, b_f, w_f, aw_f, f};
    endfunction

    task automatic bus_set(input logic v);
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0;
        bus.aw_burst = '0; bus.aw_lock = '0; bus.aw_cache = '0; bus.aw_prot = '0;
        bus.aw_region = '0; bus.aw_qos = '0; bus.aw_user = '0;
        bus.aw_valid = v; bus.aw_ready = v;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = '0; bus.w_user = '0;
        bus.w_valid = v; bus.w_ready = v;
        bus.b_id = '0; bus.b_resp = '0; bus.b_user = '0; bus.b_valid = v; bus.b_ready = v;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0;
        bus.ar_burst = '0; bus.ar_lock = '0; bus.ar_cache = '0; bus.ar_prot = '0;
        bus.ar_region = '0; bus.ar_qos = '0; bus.ar_user = '0;
        bus.ar_valid = v; bus.ar_ready = v;
        bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = '0; bus.r_user = '0;
        bus.r_valid = v; bus.r_ready = v;
    endtask

    // One clocked cycle with full comparison of capture, fire_o and padding
    task automatic step(input string name, input logic [4:0] f, input logic clr);
        logic [31:0]  ts_e;
        logic [411:0] exp;
        if (clr) begin
            ts_e  = '0;
            cnt_m = '0;
        end else begin
            ts_e = ts_m;
        end
        for (int i = 0; i < 5; i++) cnt_m[i] = cnt_m[i] + 16'(f[i]);
        ts_m  = ts_e + 32'd1;
        exp   = model(f, ts_e, cnt_m);
        clr_i = clr;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        check({name, " capture"}, 416'(capture[411:0]), 416'(exp));
        check({name, " fire_o"}, 416'(fire_o), 416'(f));
        check({name, " padding"}, 416'(|capture[CW-1:412]), '0);
    endtask

    // Unchecked cycles with a constant handshake pattern, keeping the reference in step
    task automatic run_raw(input int n, input logic [4:0] f);
        repeat (n) @(posedge clk);
        #1;
        ts_m = ts_m + 32'(n);
        for (int i = 0; i < 5; i++) if (f[i]) cnt_m[i] = cnt_m[i] + 16'(n);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5'b11111, 5'b11111, 32'h1234_5678, 64'h0123_4567_89AB_CDEF, 5'b11111};
        vecs[1] = '{5'b10101, 5'b01110, 32'hA5A5_0F0F, 64'hFFFF_0000_FFFF_0000, 5'b00100};
        vecs[2] = '{5'b01010, 5'b01010, 32'h0000_0001, 64'h8000_0000_0000_0001, 5'b01010};
        vecs[3] = '{5'b00000, 5'b11111, 32'hFFFF_FFFF, 64'h5555_AAAA_5555_AAAA, 5'b00000};
        vecs[4] = '{5'b11111, 5'b00000, 32'h7FFF_0000, 64'h0000_0000_0000_0007, 5'b00000};
        vecs[5] = '{5'b10001, 5'b10011, 32'hDEAD_0010, 64'h1357_9BDF_0246_8ACE, 5'b10001};
        vecs[6] = '{5'b00110, 5'b00100, 32'h0BAD_F00D, 64'hCAFE_BABE_0000_1111, 5'b00100};
        vecs[7] = '{5'b11000, 5'b01000, 32'h4000_3000, 64'hF0F0_F0F0_0F0F_0F0F, 5'b01000};

        // Reset held with live traffic
        rst_i = 1'b1;
        clr_i = 1'b0;
        bus_set(1'b1);
        bus.w_data = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset capture", 416'(|capture), '0);
            check("reset fire_o", 416'(fire_o), '0);
        end
        rst_i = 1'b0;
        ts_m  = '0;
        cnt_m = '0;
        bus_set(1'b0);
        step("post_reset", 5'b00000, 1'b0);
        check("post_reset ts", 416'(capture[331:300]), '0);

        // Single AW handshake
        bus.aw_valid = 1'b1;
        bus.aw_ready = 1'b1;
        bus.aw_addr  = 32'h8000_1000;
        bus.aw_id    = 4'd3;
        bus.aw_len   = 8'd7;
        step("aw", 5'b00001, 1'b0);
        check("aw field", 416'(capture[72:5]), 416'(68'h3_8000_1000_0700_0003));
        check("aw cnt", 416'(capture[347:332]), 416'(16'd1));

        // W valid stalled for four cycles, then accepted
        bus_set(1'b0);
        bus.w_valid = 1'b1;
        bus.w_data  = 64'h0BAD_CAFE_1234_5678;
        for (int i = 0; i < 4; i++) begin
            step("w_wait", 5'b00000, 1'b0);
            check("w_wait valid bit", 416'(capture[74]), 416'(1'b1));
        end
        bus.w_ready = 1'b1;
        step("w_fire", 5'b00010, 1'b0);
        check("w_fire valid bit", 416'(capture[74]), 416'(1'b1));
        check("w cnt", 416'(capture[363:348]), 416'(16'd1));

        // B and R handshakes in the same cycle
        bus_set(1'b0);
        bus.b_valid = 1'b1;
        bus.b_ready = 1'b1;
        bus.r_valid = 1'b1;
        bus.r_ready = 1'b1;
        bus.r_data  = 64'hDEAD_BEEF_CAFE_F00D;
        bus.r_last  = 1'b1;
        step("br", 5'b10100, 1'b0);
        check("br r_data", 416'(capture[295:232]), 416'(64'hDEAD_BEEF_CAFE_F00D));
        check("br r_low", 416'(capture[229:226]), 416'(4'b1011));
        check("br cnt_b", 416'(capture[379:364]), 416'(16'd1));
        check("br cnt_r", 416'(capture[411:396]), 416'(16'd1));

        // Table of handshake patterns
        for (int i = 0; i < 8; i++) begin
            bus_set(1'b0);
            {bus.r_valid, bus.ar_valid, bus.b_valid, bus.w_valid, bus.aw_valid} = vecs[i].valid;
            {bus.r_ready, bus.ar_ready, bus.b_ready, bus.w_ready, bus.aw_ready} = vecs[i].ready;
            bus.aw_addr  = vecs[i].addr;
            bus.ar_addr  = ~vecs[i].addr;
            bus.aw_id    = vecs[i].addr[3:0];
            bus.ar_id    = vecs[i].addr[7:4];
            bus.aw_len   = vecs[i].addr[15:8];
            bus.ar_qos   = vecs[i].addr[19:16];
            bus.w_data   = vecs[i].data;
            bus.w_strb   = vecs[i].data[7:0];
            bus.w_last   = vecs[i].data[0];
            bus.b_id     = vecs[i].data[3:0];
            bus.b_resp   = vecs[i].data[5:4];
            bus.r_id     = vecs[i].data[11:8];
            bus.r_data   = ~vecs[i].data;
            bus.r_resp   = vecs[i].data[9:8];
            bus.r_last   = vecs[i].data[1];
            bus.aw_user  = vecs[i].data[2];
            bus.r_user   = vecs[i].data[63];
            step($sformatf("vec%0d", i), vecs[i].fire, 1'b0);
        end

        // Clear during AW+W traffic; snapshot stays live
        bus_set(1'b0);
        bus.aw_valid = 1'b1; bus.aw_ready = 1'b1; bus.aw_addr = 32'hC1EA_0000;
        bus.w_valid  = 1'b1; bus.w_ready  = 1'b1; bus.w_data  = 64'h00C0_FFEE_0000_0042;
        step("clr", 5'b00011, 1'b1);
        check("clr ts", 416'(capture[331:300]), '0);
        check("clr cnt", 416'(capture[379:332]), 416'({16'd0, 16'd1, 16'd1}));
        check("clr aw_addr", 416'(capture[68:37]), 416'(32'hC1EA_0000));
        step("after_clr", 5'b00011, 1'b0);

        // AR counter wrap after 65537 handshakes
        bus_set(1'b0);
        step("pre_wrap", 5'b00000, 1'b1);
        bus.ar_valid = 1'b1;
        bus.ar_ready = 1'b1;
        run_raw(65536, 5'b01000);
        step("wrap", 5'b01000, 1'b0);
        check("wrap cnt_ar", 416'(capture[395:380]), 416'(16'd1));

        // Timestamp rollover from a forced maximum
        bus_set(1'b0);
        force dut.ts_now = 32'hFFFF_FFFF;
        ts_m = 32'hFFFF_FFFF;
        step("ts_max", 5'b00000, 1'b0);
        release dut.ts_now;
        step("ts_wrap", 5'b00000, 1'b0);
        check("ts_wrap ts", 416'(capture[331:300]), '0);

        // Reset together with clear and traffic
        bus_set(1'b1);
        rst_i = 1'b1;
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_clr capture", 416'(|capture), '0);
        check("rst_clr fire_o", 416'(fire_o), '0);
        rst_i = 1'b0;
        clr_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
